// File: rtl/alu_pkg.sv
// ============================================================================
//  Package     : alu_pkg
//  Description : Opcode and FSM state types shared by iter_alu and its
//                iterative multiply/divide core, plus small opcode
//                classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Base opcodes keep the legacy 4-bit encoding, zero-extended to 5 bits.
  // M-extension opcodes occupy 16..23.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } iter_state_e;

  function automatic logic is_muldiv(alu_op_e op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_mul(alu_op_e op);
    return (op >= ALU_MUL) && (op <= ALU_MULHU);
  endfunction

  function automatic logic is_div(alu_op_e op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_signed_div(alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
//  Module      : muldiv_iter
//  Description : Radix-2 iterative core. Unsigned shift-add multiplier or
//                restoring divider, one bit per cycle for width_p cycles.
//                Operands are unsigned; sign handling lives in the caller.
//  Ports       : clk_i, rst_ni (async active-low), abort_i (sync cancel),
//                start_i/div_i/a_i/b_i (launch), done_o (last iteration
//                this cycle), hi_o/lo_o (product hi/lo, or remainder/quotient)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               abort_i,
  input  logic               start_i,
  input  logic               div_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic               done_o,
  output logic [width_p-1:0] hi_o,
  output logic [width_p-1:0] lo_o
);

  localparam int cnt_w_lp = $clog2(width_p);

  logic                busy_q, busy_d;
  logic                div_q, div_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic [width_p-1:0]  b_q, b_d;
  logic [width_p-1:0]  hi_q, hi_d;
  logic [width_p-1:0]  lo_q, lo_d;
  logic [width_p:0]    mul_sum;
  logic [width_p:0]    div_shift;
  logic [width_p:0]    div_diff;

  assign done_o = busy_q && (cnt_q == cnt_w_lp'(width_p - 1));
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;

    // Multiply: {hi,lo} starts as {0,multiplier}; add multiplicand to hi when
    // lo[0] is set, then shift the whole pair right with the carry.
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    // Divide: {hi,lo} starts as {0,dividend}; shift left, trial-subtract the
    // divisor from the partial remainder. Bit width_p of the difference is
    // the borrow because the partial remainder is always below 2*divisor.
    div_shift = {hi_q, lo_q[width_p-1]};
    div_diff  = div_shift - {1'b0, b_q};

    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      div_d  = div_i;
      cnt_d  = '0;
      b_d    = b_i;
      hi_d   = '0;
      lo_d   = a_i;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        if (!div_diff[width_p]) begin
          hi_d = div_diff[width_p-1:0];
          lo_d = {lo_q[width_p-2:0], 1'b1};
        end else begin
          hi_d = div_shift[width_p-1:0];
          lo_d = {lo_q[width_p-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[width_p:1];
        lo_d = {mul_sum[0], lo_q[width_p-1:1]};
      end
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/iter_alu.sv
// ============================================================================
//  Module      : iter_alu
//  Description : Handshaked ALU with RV32M-style multiply/divide/remainder.
//                Base ops and divide corner cases complete in one registered
//                cycle; MUL*/DIV*/REM* run on the iterative muldiv_iter core.
//  Ports       : clk_i, rst_ni (async active-low), flush_i (sync abort)
//                in_valid_i/in_ready_o, op_i, d1_i, d2_i      (request)
//                out_valid_o/out_ready_i, result_o, zero_o, sign_o (result)
//  Config      : ITER_ALU_FAST_MUL_EN - MUL* use one registered full-width
//                multiplier (latency 2); DIV/REM stay iterative.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_alu
  import alu_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [4:0]         op_i,
  input  logic [width_p-1:0] d1_i,
  input  logic [width_p-1:0] d2_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [width_p-1:0] result_o,
  output logic               zero_o,
  output logic               sign_o
);

  localparam int                 shamt_w_lp  = $clog2(width_p);
  localparam logic [width_p-1:0] min_neg_lp  = {1'b1, {(width_p-1){1'b0}}};

  iter_state_e          state_q, state_d;
  alu_op_e              op_in, op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 out_valid_q, out_valid_d;
  logic [width_p-1:0]   result_q, result_d;

  logic [shamt_w_lp-1:0] shamt;
  logic                 sign_a, sign_b, take_abs_a, take_abs_b, neg_in, div_in;
  logic                 accept, div_zero, div_ovf, bypass;
  logic [width_p-1:0]   abs_a, abs_b, base_res, bypass_res, done_res;
  logic [width_p-1:0]   core_hi, core_lo;
  logic [2*width_p-1:0] full_prod, prod_fix;
  logic                 core_start, core_done;

`ifdef ITER_ALU_FAST_MUL_EN
  logic [2*width_p-1:0] prod_q, prod_d;
`endif

  assign op_in  = alu_op_e'(op_i);
  assign shamt  = d2_i[shamt_w_lp-1:0];
  assign sign_a = d1_i[width_p-1];
  assign sign_b = d2_i[width_p-1];
  assign div_in = is_div(op_in);

  // Signed M ops run on magnitudes; the result sign is restored in DONE.
  // MUL needs no fix-up: the low half is identical for signed/unsigned.
  assign take_abs_a = (op_in == ALU_MULH) || (op_in == ALU_MULHSU) || is_signed_div(op_in);
  assign take_abs_b = (op_in == ALU_MULH) || is_signed_div(op_in);
  assign abs_a      = (take_abs_a && sign_a) ? -d1_i : d1_i;
  assign abs_b      = (take_abs_b && sign_b) ? -d2_i : d2_i;
  // Remainder follows the dividend; quotient/product follow the sign product.
  assign neg_in     = ((op_in == ALU_MULH) || (op_in == ALU_DIV)) ? (sign_a ^ sign_b) :
                      ((op_in == ALU_MULHSU) || (op_in == ALU_REM)) ? sign_a : 1'b0;

  assign div_zero   = div_in && (d2_i == '0);
  assign div_ovf    = is_signed_div(op_in) && (d1_i == min_neg_lp) && (d2_i == '1);
  assign bypass     = div_zero || div_ovf;
  assign bypass_res = div_zero ? (((op_in == ALU_DIV) || (op_in == ALU_DIVU)) ? '1 : d1_i)
                               : ((op_in == ALU_DIV) ? d1_i : '0);

  assign in_ready_o = (state_q == IDLE) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o && !flush_i;

`ifdef ITER_ALU_FAST_MUL_EN
  assign full_prod = is_mul(op_q) ? prod_q : {core_hi, core_lo};
`else
  assign full_prod = {core_hi, core_lo};
`endif
  assign prod_fix = neg_q ? -full_prod : full_prod;

  always_comb begin
    base_res = '0;
    case (op_in)
      ALU_ADD:  base_res = d1_i + d2_i;
      ALU_SUB:  base_res = d1_i - d2_i;
      ALU_AND:  base_res = d1_i & d2_i;
      ALU_OR:   base_res = d1_i | d2_i;
      ALU_XOR:  base_res = d1_i ^ d2_i;
      ALU_SLL:  base_res = d1_i << shamt;
      ALU_SRL:  base_res = d1_i >> shamt;
      ALU_SRA:  base_res = $signed(d1_i) >>> shamt;
      ALU_SLT:  base_res = {{(width_p-1){1'b0}}, ($signed(d1_i) < $signed(d2_i))};
      ALU_SLTU: base_res = {{(width_p-1){1'b0}}, (d1_i < d2_i)};
      default:  base_res = '0;
    endcase
  end

  always_comb begin
    done_res = '0;
    case (op_q)
      ALU_MUL:                          done_res = full_prod[width_p-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  done_res = prod_fix[2*width_p-1:width_p];
      ALU_DIV, ALU_DIVU:                done_res = neg_q ? -full_prod[width_p-1:0]
                                                         :  full_prod[width_p-1:0];
      ALU_REM, ALU_REMU:                done_res = neg_q ? -full_prod[2*width_p-1:width_p]
                                                         :  full_prod[2*width_p-1:width_p];
      default:                          done_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q && !out_ready_i;
    core_start  = 1'b0;
`ifdef ITER_ALU_FAST_MUL_EN
    prod_d      = prod_q;
`endif

    if (flush_i) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_d  = op_in;
            neg_d = neg_in;
            if (is_muldiv(op_in) && !bypass) begin
`ifdef ITER_ALU_FAST_MUL_EN
              if (is_mul(op_in)) begin
                prod_d  = {{width_p{1'b0}}, abs_a} * {{width_p{1'b0}}, abs_b};
                state_d = DONE;
              end else begin
                core_start = 1'b1;
                state_d    = CALC;
              end
`else
              core_start = 1'b1;
              state_d    = CALC;
`endif
            end else begin
              result_d    = bypass ? bypass_res : base_res;
              out_valid_d = 1'b1;
            end
          end
        end
        CALC: begin
          if (core_done) begin
            state_d = DONE;
          end
        end
        DONE: begin
          result_d    = done_res;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= ALU_ADD;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

`ifdef ITER_ALU_FAST_MUL_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end
`endif

  muldiv_iter #(.width_p(width_p)) u_core (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .abort_i (flush_i),
    .start_i (core_start),
    .div_i   (div_in),
    .a_i     (abs_a),
    .b_i     (abs_b),
    .done_o  (core_done),
    .hi_o    (core_hi),
    .lo_o    (core_lo)
  );

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = (result_q == '0);
  assign sign_o      = result_q[width_p-1];

endmodule

`default_nettype wire
